// File: rtl/sha256_digest_collector_if.sv
// Digest-stream interface between the hasher side (master) and the collector (slave).
// Carries the beat stream, arm/compare controls and the collector status outputs.
interface sha256_digest_collector_if #(
    parameter int IN_W     = 16,
    parameter int DIGEST_W = 256
);
    logic                start;
    logic                in_valid;
    logic [IN_W-1:0]     in_data;
    logic                cmp_enable;
    logic [DIGEST_W-1:0] expected_digest;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;
    logic                match;
    logic                busy;
    logic [1:0]          err_code;
    logic [4:0]          beat_count;

    modport master (
        output start, in_valid, in_data, cmp_enable, expected_digest,
        input  digest, digest_valid, match, busy, err_code, beat_count
    );

    modport slave (
        input  start, in_valid, in_data, cmp_enable, expected_digest,
        output digest, digest_valid, match, busy, err_code, beat_count
    );
endinterface

// File: rtl/sha256_digest_collector.sv
// Collects BEATS consecutive IN_W-bit beats (MSB beat first) into a DIGEST_W-bit digest,
// optionally compares it with a reference, and reports sticky timeout/overflow errors.
module sha256_digest_collector #(
    parameter int IN_W           = 16,
    parameter int DIGEST_W       = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                      clock,
    input logic                      reset,
    sha256_digest_collector_if.slave bus
);
    localparam int BEATS = DIGEST_W / IN_W;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0]      BEATS_C   = 5'(BEATS);
    localparam logic [4:0]      LAST_C    = 5'(BEATS - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [DIGEST_W-1:0] shift_r, shift_s;
    logic [DIGEST_W-1:0] digest_r, digest_s;
    logic                valid_r, valid_s;
    logic                match_r, match_s;
    logic [1:0]          err_r, err_s;
    logic [4:0]          count_r, count_s;
    logic [TO_W-1:0]     tcnt_r, tcnt_s;
    logic [DIGEST_W-1:0] assembled_s;

    // Next-state and next-output computation; start overrides everything, including a same-cycle beat.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        digest_s    = digest_r;
        valid_s     = valid_r;
        match_s     = match_r;
        err_s       = err_r;
        count_s     = count_r;
        tcnt_s      = tcnt_r;
        assembled_s = {shift_r[DIGEST_W-IN_W-1:0], bus.in_data};

        if (bus.start) begin
            state_s = COLLECT;
            shift_s = '0;
            count_s = 5'd0;
            tcnt_s  = '0;
            valid_s = 1'b0;
            match_s = 1'b0;
            err_s   = 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                COLLECT: begin
                    if (bus.in_valid) begin
                        shift_s = assembled_s;
                        tcnt_s  = '0;
                        if (count_r >= LAST_C) begin
                            digest_s = assembled_s;
                            valid_s  = 1'b1;
                            match_s  = bus.cmp_enable && (assembled_s == bus.expected_digest);
                            count_s  = BEATS_C;
                            state_s  = DONE;
                        end else begin
                            count_s = count_r + 5'd1;
                        end
                    end else if (tcnt_r >= TO_LAST) begin
                        // Partial data is abandoned; the previous digest stays visible.
                        tcnt_s  = TO_MAX;
                        err_s   = err_r | 2'b01;
                        valid_s = 1'b0;
                        match_s = 1'b0;
                        state_s = DONE;
                    end else begin
                        tcnt_s = tcnt_r + TO_ONE;
                    end
                end
                DONE: begin
                    if (bus.in_valid) begin
                        err_s = err_r | 2'b10;
                    end else begin
                        err_s = err_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            digest_r <= '0;
            valid_r  <= 1'b0;
            match_r  <= 1'b0;
            err_r    <= 2'b00;
            count_r  <= 5'd0;
            tcnt_r   <= '0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            digest_r <= digest_s;
            valid_r  <= valid_s;
            match_r  <= match_s;
            err_r    <= err_s;
            count_r  <= count_s;
            tcnt_r   <= tcnt_s;
        end
    end

    assign bus.digest       = digest_r;
    assign bus.digest_valid = valid_r;
    assign bus.match        = match_r;
    assign bus.busy         = (state_r == COLLECT);
    assign bus.err_code     = err_r;
    assign bus.beat_count   = count_r;
endmodule

// File: tb/tb_sha256_digest_collector.sv
// Directed bench for sha256_digest_collector: a queue-based digest model checked every
// falling edge, plus literal expectations for the SHA256("abc") known-answer vector.
module tb_sha256_digest_collector;
    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    sha256_digest_collector_if bus ();

    sha256_digest_collector dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] abc_beats [16] = '{16'hba78, 16'h16bf, 16'h8f01, 16'hcfea, 16'h4141, 16'h40de,
                                    16'h5dae, 16'h2223, 16'hb003, 16'h61a3, 16'h9617, 16'h7a9c,
                                    16'hb410, 16'hff61, 16'hf200, 16'h15ad};

    // Model: 0 idle, 1 collecting, 2 finished
    int           m_phase;
    logic [15:0]  m_beats [$];
    int           m_idle;
    logic [255:0] m_digest;
    logic         m_valid;
    logic         m_match;
    logic [1:0]   m_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_beats.delete();
        m_idle   = 0;
        m_digest = '0;
        m_valid  = 1'b0;
        m_match  = 1'b0;
        m_err    = 2'b00;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [15:0] d);
        logic [255:0] acc;
        if (s) begin
            m_phase = 1;
            m_beats.delete();
            m_idle  = 0;
            m_valid = 1'b0;
            m_match = 1'b0;
            m_err   = 2'b00;
        end else if (m_phase == 1) begin
            if (v) begin
                m_beats.push_back(d);
                m_idle = 0;
                if (m_beats.size() == 16) begin
                    acc = '0;
                    foreach (m_beats[i]) acc = {acc[239:0], m_beats[i]};
                    m_digest = acc;
                    m_valid  = 1'b1;
                    m_match  = bus.cmp_enable && (acc == bus.expected_digest);
                    m_phase  = 2;
                end
            end else begin
                m_idle++;
                if (m_idle == 64) begin
                    m_err   = m_err | 2'b01;
                    m_valid = 1'b0;
                    m_match = 1'b0;
                    m_phase = 2;
                end
            end
        end else if (m_phase == 2 && v) begin
            m_err = m_err | 2'b10;
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic s, input logic v, input logic [15:0] d);
        bus.start    = s;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clock);
        if (!reset) model_step(s, v, d);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_abc(input int gap);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, abc_beats[i]);
            if (i != 15) repeat (gap) cyc(1'b0, 1'b0, 16'h0000);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("digest", bus.digest, m_digest);
            chk("digest_valid", 256'(bus.digest_valid), 256'(m_valid));
            chk("match", 256'(bus.match), 256'(m_match));
            chk("busy", 256'(bus.busy), 256'(m_phase == 1));
            chk("err_code", 256'(bus.err_code), 256'(m_err));
            chk("beat_count", 256'(bus.beat_count), 256'(m_beats.size()));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0000;
        bus.cmp_enable = 1'b1;
        bus.expected_digest = ABC;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_valid", 256'(bus.digest_valid), 256'd0);
        chk("rst_count", 256'(bus.beat_count), 256'd0);

        // in_valid before any start is ignored
        cyc(1'b0, 1'b1, 16'h1234);
        cyc(1'b0, 1'b1, 16'h5678);
        chk("idle_ignore_count", 256'(bus.beat_count), 256'd0);
        chk("idle_ignore_busy", 256'(bus.busy), 256'd0);

        // Known-answer vector, back-to-back beats
        cyc(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, abc_beats[i]);
        chk("kat_not_yet", 256'(bus.digest_valid), 256'd0);
        chk("kat_count15", 256'(bus.beat_count), 256'd15);
        cyc(1'b0, 1'b1, abc_beats[15]);
        chk("kat_valid", 256'(bus.digest_valid), 256'd1);
        chk("kat_digest", bus.digest, ABC);
        chk("kat_match", 256'(bus.match), 256'd1);
        chk("kat_err", 256'(bus.err_code), 256'd0);
        chk("kat_count16", 256'(bus.beat_count), 256'd16);

        // Overflow beat after completion, then re-arm
        cyc(1'b0, 1'b1, 16'hdead);
        chk("ovf_err", 256'(bus.err_code), 256'd2);
        chk("ovf_digest", bus.digest, ABC);
        chk("ovf_match", 256'(bus.match), 256'd1);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("rearm_err", 256'(bus.err_code), 256'd0);
        chk("rearm_valid", 256'(bus.digest_valid), 256'd0);
        chk("rearm_count", 256'(bus.beat_count), 256'd0);

        // Mismatching reference, then compare disabled
        bus.expected_digest = ABC ^ 256'd1;
        send_abc(0);
        chk("miss_valid", 256'(bus.digest_valid), 256'd1);
        chk("miss_match", 256'(bus.match), 256'd0);
        bus.expected_digest = ABC;
        bus.cmp_enable = 1'b0;
        cyc(1'b1, 1'b0, 16'h0000);
        send_abc(0);
        chk("nocmp_match", 256'(bus.match), 256'd0);
        bus.cmp_enable = 1'b1;

        // Timeout after 5 beats: 63 idle cycles survive, the 64th trips
        cyc(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h1111);
        repeat (63) cyc(1'b0, 1'b0, 16'h0000);
        chk("to_63_busy", 256'(bus.busy), 256'd1);
        chk("to_63_err", 256'(bus.err_code), 256'd0);
        cyc(1'b0, 1'b0, 16'h0000);
        chk("to_err", 256'(bus.err_code), 256'd1);
        chk("to_busy", 256'(bus.busy), 256'd0);
        chk("to_valid", 256'(bus.digest_valid), 256'd0);
        chk("to_digest_kept", bus.digest, ABC);

        // Gaps of 63 idle cycles complete normally
        cyc(1'b1, 1'b0, 16'h0000);
        send_abc(63);
        chk("gap_valid", 256'(bus.digest_valid), 256'd1);
        chk("gap_match", 256'(bus.match), 256'd1);
        chk("gap_err", 256'(bus.err_code), 256'd0);

        // Restart mid-collection discards the partial digest
        cyc(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'hffff);
        cyc(1'b1, 1'b0, 16'h0000);
        send_abc(0);
        chk("restart_digest", bus.digest, ABC);
        chk("restart_match", 256'(bus.match), 256'd1);

        // Start coincident with a beat drops that beat
        cyc(1'b1, 1'b1, 16'hffff);
        chk("startbeat_count", 256'(bus.beat_count), 256'd0);
        chk("startbeat_busy", 256'(bus.busy), 256'd1);

        // Asynchronous reset mid-collection
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, abc_beats[i]);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_digest", bus.digest, 256'd0);
        chk("arst_valid", 256'(bus.digest_valid), 256'd0);
        chk("arst_busy", 256'(bus.busy), 256'd0);
        chk("arst_count", 256'(bus.beat_count), 256'd0);
        chk("arst_err", 256'(bus.err_code), 256'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, 16'h4242);
        chk("post_rst_ignore", 256'(bus.beat_count), 256'd0);
        chk("post_rst_busy", 256'(bus.busy), 256'd0);
        repeat (2) cyc(1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
